timer_capture: RTL and testbench
================================

TIMER_CAPTURE -- requirements
Module: timer_capture

Interface
REQ-001 Parameter TIMER_ADDITIONAL_BITS, default 8, sets prescaler width; the count advances once every 2**TIMER_ADDITIONAL_BITS clk cycles.
REQ-002 Parameter SYNC_STAGES, default 2, sets the number of synchronizer flops on event_in (minimum 2).
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset; sampled only on rising clk edges.
REQ-005 write  input  1  control-register write strobe, one cycle.
REQ-006 data_in  input  32  control word: bit0 ARM, bit1 EDGE (0 rising, 1 falling); bits 31:2 ignored.
REQ-007 event_in  input  1  asynchronous external event line to be timed.
REQ-008 read  input  1  acknowledge strobe; clears a pending capture.
REQ-009 capture_interrupt  output  1  high while a capture is pending.
REQ-010 data_out  output  32  last captured count, in prescaled ticks.
REQ-011 busy  output  1  high while ARMED.

Function
REQ-012 States SHALL be IDLE, ARMED, CAPTURED; busy = (state==ARMED), capture_interrupt = (state==CAPTURED), both registered.
REQ-013 write with ARM=1 in any state SHALL, on the next cycle, enter ARMED, clear prescaler and count to 0, and latch EDGE.
REQ-014 write with ARM=0 SHALL return to IDLE from any state; data_out SHALL be unchanged.
REQ-015 In ARMED the prescaler SHALL increment every cycle; on prescaler wrap to 0 the 32-bit count SHALL increment by 1.
REQ-016 event_in SHALL pass through SYNC_STAGES flops, then one history flop; an edge is detected when the synchronized and history values match the latched EDGE polarity.
REQ-017 An edge detected in ARMED SHALL load data_out with the count value of that cycle (before any increment that cycle) and enter CAPTURED on the next cycle.
REQ-018 Pin-to-interrupt latency SHALL be SYNC_STAGES+1 cycles from the first clk edge sampling the new event_in level.
REQ-019 Measured value SHALL equal floor(cycles from entering ARMED to edge detection / 2**TIMER_ADDITIONAL_BITS).
REQ-020 If count reaches 0xFFFFFFFF in ARMED it SHALL saturate; on the next prescaler wrap data_out SHALL load 0xFFFFFFFF and the block SHALL enter CAPTURED (timeout).
REQ-021 read in CAPTURED SHALL enter IDLE next cycle; read in IDLE or ARMED SHALL have no effect.
REQ-022 Simultaneous write and read: write SHALL take priority.
REQ-023 Edge detected in the same cycle as an ARM write: the write SHALL win; the edge is discarded and counting restarts at 0.
REQ-024 Edges in IDLE or CAPTURED SHALL be ignored; data_out SHALL hold until the next capture.
REQ-025 Synchronizer and history flops SHALL track event_in in every state so no false edge occurs on arming.

Reset
REQ-026 With rst=0 at a rising edge: state IDLE, busy=0, capture_interrupt=0, data_out=0, prescaler=0, count=0, EDGE=0.
REQ-027 Synchronizer and history flops SHALL reset to 0; a high event_in after reset release SHALL register as a rising edge only once synchronized, and SHALL be ignored unless ARMED.
REQ-028 Reset asserted mid-capture (ARMED or CAPTURED) SHALL abort to IDLE on that edge with no interrupt produced.

Verification
REQ-029 TAB=8; arm rising (data_in=1); raise event_in 2560 cycles after ARMED entry minus sync latency -> data_out=10, capture_interrupt high, busy low.
REQ-030 Arm falling (data_in=3), event_in held high then dropped after ~512 cycles -> data_out=2; a rising edge earlier in the window produces no capture.
REQ-031 Capture pending, read=1 one cycle -> capture_interrupt low next cycle, state IDLE, data_out unchanged; a later edge causes no interrupt.
REQ-032 Arm, then write data_in=0 after 100 cycles, then toggle event_in -> busy low, no interrupt, data_out holds previous value.
REQ-033 Edge detection coincident with ARM write -> no capture; subsequent edge 768 cycles later -> data_out=3.
REQ-034 rst=0 while ARMED and while CAPTURED -> all outputs at reset values next cycle; ten random arm/event delays 0-2000 ticks -> data_out matches every time.

Source files
------------

// File: rtl/timer_capture.sv
// timer_capture: measures the delay from arming to an edge on an asynchronous
// event line, in prescaled ticks of 2**TIMER_ADDITIONAL_BITS clk cycles.
//
// Ports:
//   clk               system clock, all state changes on the rising edge
//   rst               synchronous active-low reset
//   write             control write strobe (data_in[0]=ARM, data_in[1]=EDGE)
//   data_in           control word; bits 31:2 ignored
//   event_in          asynchronous event line
//   read              acknowledge strobe, clears a pending capture
//   capture_interrupt high while a capture is pending
//   data_out          last captured tick count
//   busy              high while armed
//
// TIMER_ADDITIONAL_BITS must be at least 1; SYNC_STAGES below 2 is raised to 2.
module timer_capture #(
  parameter int unsigned TIMER_ADDITIONAL_BITS = 8,
  parameter int unsigned SYNC_STAGES           = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        write,
  input  logic [31:0] data_in,
  input  logic        event_in,
  input  logic        read,
  output logic        capture_interrupt,
  output logic [31:0] data_out,
  output logic        busy
);

  localparam int unsigned PW = TIMER_ADDITIONAL_BITS;
  localparam int unsigned CW = 32;
  localparam int unsigned SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CAPTURED = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   data_d;
  logic            pol_q, pol_d;
  logic [SS-1:0]   sync_q;
  logic            hist_q;
  logic            sync_lvl;
  logic            edge_det;
  logic            presc_wrap;
  logic            ctrl_unused;

  assign ctrl_unused = ^data_in[31:2];

  // Synchronizer and history run in every state so arming never sees a stale edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SS-2:0], event_in};
      hist_q <= sync_q[SS-1];
    end
  end

  assign sync_lvl   = sync_q[SS-1];
  assign edge_det   = pol_q ? (hist_q & ~sync_lvl) : (~hist_q & sync_lvl);
  assign presc_wrap = &presc_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      presc_q  <= '0;
      count_q  <= '0;
      data_out <= '0;
      pol_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      presc_q  <= presc_d;
      count_q  <= count_d;
      data_out <= data_d;
      pol_q    <= pol_d;
    end
  end

  // Next-state logic: write beats everything (including a same-cycle edge or read).
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    count_d = count_q;
    data_d  = data_out;
    pol_d   = pol_q;

    if (write) begin
      if (data_in[0]) begin
        state_d = ARMED;
        presc_d = '0;
        count_d = '0;
        pol_d   = data_in[1];
      end else begin
        state_d = IDLE;
      end
    end else begin
      case (state_q)
        IDLE: ;
        ARMED: begin
          presc_d = presc_q + PW'(1);
          if (edge_det) begin
            // Capture the count of this cycle, before any increment.
            data_d  = count_q;
            state_d = CAPTURED;
          end else if (presc_wrap) begin
            if (&count_q) begin
              // Saturated count followed by another full tick: timeout.
              data_d  = '1;
              state_d = CAPTURED;
            end else begin
              count_d = count_q + CW'(1);
            end
          end
        end
        CAPTURED: begin
          if (read) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Status outputs are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      busy              <= 1'b0;
      capture_interrupt <= 1'b0;
    end else begin
      busy              <= (state_d == ARMED);
      capture_interrupt <= (state_d == CAPTURED);
    end
  end

endmodule

// File: tb/tb_timer_capture.sv
// Bench for timer_capture: stimulus pushes expected captures into a queue, a
// monitor pops and compares on every rising edge of capture_interrupt.
module tb_timer_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        write = 1'b0;
  logic [31:0] data_in = '0;
  logic        event_in = 1'b0;
  logic        read = 1'b0;
  logic        capture_interrupt;
  logic [31:0] data_out;
  logic        busy;

  int unsigned exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        irq_prev = 1'b0;

  timer_capture #(.TIMER_ADDITIONAL_BITS(8), .SYNC_STAGES(2)) dut (
    .clk               (clk),
    .rst               (rst),
    .write             (write),
    .data_in           (data_in),
    .event_in          (event_in),
    .read              (read),
    .capture_interrupt (capture_interrupt),
    .data_out          (data_out),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  // Monitor: each new interrupt must match the oldest expected capture.
  always @(negedge clk) begin
    if (capture_interrupt && !irq_prev) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_irq: got data_out=%0d expected no interrupt", data_out);
      end else begin
        chk("capture_value", data_out, exp_q.pop_front());
        chk("busy_at_irq", {31'd0, busy}, 32'd0);
      end
    end
    irq_prev = capture_interrupt;
  end

  // Advance n rising edges and settle just after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] d);
    write   = 1'b1;
    data_in = d;
    tick(1);
    write   = 1'b0;
    data_in = '0;
  endtask

  task automatic do_read();
    read = 1'b1;
    tick(1);
    read = 1'b0;
  endtask

  task automatic wait_irq();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (capture_interrupt) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL irq_timeout: got no interrupt within 20 cycles expected one");
    end
    @(posedge clk);
    #1;
  endtask

  // After n more cycles drive event_in to lvl and expect a capture of exp.
  // Edge seen k = (cycles since arming at lvl change) + 2 cycles after arming.
  task automatic expect_edge(input int n, input logic lvl, input int unsigned exp);
    tick(n);
    exp_q.push_back(exp);
    event_in = lvl;
    wait_irq();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;

    // Reset values
    tick(3);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_irq", {31'd0, capture_interrupt}, 32'd0);
    chk("rst_data", data_out, 32'd0);
    rst = 1'b1;
    tick(2);

    // Rising capture exactly on the 10-tick boundary: k = 2558 + 2 = 2560
    do_write(32'd1);
    chk("armed_busy", {31'd0, busy}, 32'd1);
    expect_edge(2558, 1'b1, 10);
    chk("cap_irq", {31'd0, capture_interrupt}, 32'd1);

    // Read clears; later edges ignored
    do_read();
    chk("read_irq", {31'd0, capture_interrupt}, 32'd0);
    chk("read_busy", {31'd0, busy}, 32'd0);
    chk("read_hold", data_out, 32'd10);
    event_in = 1'b0; tick(5);
    event_in = 1'b1; tick(5);
    chk("idle_edge_irq", {31'd0, capture_interrupt}, 32'd0);
    chk("idle_edge_hold", data_out, 32'd10);
    event_in = 1'b0; tick(5);

    // Falling capture; the earlier rising edge must not capture. k = 612
    do_write(32'd3);
    tick(100);
    event_in = 1'b1;
    expect_edge(510, 1'b0, 2);
    do_read();

    // Tick boundary: k = 767 -> 2, k = 768 -> 3
    do_write(32'd1);
    expect_edge(765, 1'b1, 2);
    do_read();
    event_in = 1'b0; tick(4);
    do_write(32'd1);
    expect_edge(766, 1'b1, 3);
    do_read();
    event_in = 1'b0; tick(4);

    // Disarm: no interrupt, data_out held
    do_write(32'd1);
    tick(100);
    do_write(32'd0);
    chk("disarm_busy", {31'd0, busy}, 32'd0);
    event_in = 1'b1; tick(5);
    event_in = 1'b0; tick(5);
    chk("disarm_irq", {31'd0, capture_interrupt}, 32'd0);
    chk("disarm_hold", data_out, 32'd3);

    // Edge detection coincident with re-arm write: write wins, count restarts
    do_write(32'd1);
    tick(20);
    event_in = 1'b1;
    tick(2);
    do_write(32'd1);
    chk("coinc_busy", {31'd0, busy}, 32'd1);
    chk("coinc_irq", {31'd0, capture_interrupt}, 32'd0);
    tick(10);
    event_in = 1'b0;
    expect_edge(790, 1'b1, 3);
    do_read();
    event_in = 1'b0; tick(4);

    // Reset while ARMED
    do_write(32'd1);
    tick(50);
    rst = 1'b0; tick(1); rst = 1'b1;
    chk("rst_armed_busy", {31'd0, busy}, 32'd0);
    chk("rst_armed_irq", {31'd0, capture_interrupt}, 32'd0);
    chk("rst_armed_data", data_out, 32'd0);

    // Reset while CAPTURED (k = 302 -> 1)
    do_write(32'd1);
    expect_edge(300, 1'b1, 1);
    rst = 1'b0; tick(1); rst = 1'b1;
    chk("rst_cap_busy", {31'd0, busy}, 32'd0);
    chk("rst_cap_irq", {31'd0, capture_interrupt}, 32'd0);
    chk("rst_cap_data", data_out, 32'd0);
    // event_in still high: resynchronized rising edge in IDLE is ignored
    tick(5);
    chk("post_rst_edge_irq", {31'd0, capture_interrupt}, 32'd0);
    event_in = 1'b0; tick(4);

    // Random arm-to-event delays
    for (int i = 0; i < 10; i++) begin
      n = $urandom_range(0, 2000);
      do_write(32'd1);
      expect_edge(int'(n), 1'b1, (n + 2) / 256);
      do_read();
      chk("rand_hold", data_out, (n + 2) / 256);
      event_in = 1'b0; tick(4);
    end

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
